// File: rtl/toy_arb_pkg.sv
// Shared types and default parameters for the RISC_TOY fetch/data memory arbiter.
// The optional timeout logic in toy_mem_arbiter is enabled with `define ARB_TIMEOUT_EN.
package toy_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  localparam int DEF_STARVE_MAX = 3;
  localparam int DEF_TIMEOUT    = 15;

  function automatic owner_e state_owner(arb_state_e s);
    case (s)
      IBUSY:   return OWN_I;
      DBUSY:   return OWN_D;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/toy_arb_pick.sv
// Priority decision between fetch and data requesters, with the starvation
// counter that forces a fetch grant after a run of data grants.
module toy_arb_pick
  import toy_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       IREQ,
  input  logic       DREQ,
  input  logic       IVALID,
  input  logic       DVALID,
  input  arb_state_e state,
  output logic       grant_i,
  output logic       grant_d
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt;
  logic          elig_i;
  logic          elig_d;
  logic          data_first;

  // A port whose VALID is showing this cycle is finishing, not asking again.
  assign elig_i     = IREQ & ~IVALID;
  assign elig_d     = DREQ & ~DVALID;
  assign data_first = starve_cnt < CW'(STARVE_MAX);

  assign grant_d = (state == IDLE) & elig_d & (~elig_i | data_first);
  assign grant_i = (state == IDLE) & elig_i & ~(elig_d & data_first);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      starve_cnt <= '0;
    end else if (!IREQ || grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && data_first) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/toy_mem_arbiter.sv
// Shares one single-port memory between the RISC_TOY fetch and data ports.
// Define ARB_TIMEOUT_EN to abort accesses that never see MREADY.
module toy_mem_arbiter
  import toy_arb_pkg::*;
#(
  parameter int AW         = 30,
  parameter int DW         = 32,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IREQ,
  input  logic [AW-1:0] IADDR,
  output logic [DW-1:0] IRDATA,
  output logic          IVALID,
  output logic          ISTALL,
  input  logic          DREQ,
  input  logic          DRW,
  input  logic [AW-1:0] DADDR,
  input  logic [DW-1:0] DWDATA,
  output logic [DW-1:0] DRDATA,
  output logic          DVALID,
  output logic          DSTALL,
  output logic          MREQ,
  output logic          MRW,
  output logic [AW-1:0] MADDR,
  output logic [DW-1:0] MWDATA,
  input  logic [DW-1:0] MRDATA,
  input  logic          MREADY,
  output logic          ERR
);

  arb_state_e state_q;
  arb_state_e state_d;
  owner_e     owner;
  logic       grant_i;
  logic       grant_d;
  logic       busy;
  logic       complete;
  logic       timeout;

  assign owner    = state_owner(state_q);
  assign busy     = owner != OWN_NONE;
  assign complete = busy & MREADY;

  assign ISTALL = IREQ & ~IVALID;
  assign DSTALL = DREQ & ~DVALID;

  toy_arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .IREQ   (IREQ),
    .DREQ   (DREQ),
    .IVALID (IVALID),
    .DVALID (DVALID),
    .state  (state_q),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] busy_cnt;

  // busy_cnt holds the number of busy cycles already spent without MREADY.
  assign timeout = busy & ~MREADY & (busy_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      busy_cnt <= '0;
      ERR      <= 1'b0;
    end else begin
      if (grant_i || grant_d) begin
        busy_cnt <= '0;
      end else if (busy) begin
        busy_cnt <= busy_cnt + TW'(1);
      end
      if (timeout) begin
        ERR <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT;
  assign timeout            = 1'b0;
  assign ERR                = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = DBUSY;
        end else if (grant_i) begin
          state_d = IBUSY;
        end
      end
      IBUSY, DBUSY: begin
        if (complete || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side registers plus completion routing; an aborted read returns zero.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      MREQ   <= 1'b0;
      MRW    <= 1'b0;
      MADDR  <= '0;
      MWDATA <= '0;
      IRDATA <= '0;
      DRDATA <= '0;
      IVALID <= 1'b0;
      DVALID <= 1'b0;
    end else begin
      IVALID <= 1'b0;
      DVALID <= 1'b0;
      if (grant_d) begin
        MREQ   <= 1'b1;
        MRW    <= DRW;
        MADDR  <= DADDR;
        MWDATA <= DWDATA;
      end else if (grant_i) begin
        MREQ  <= 1'b1;
        MRW   <= 1'b0;
        MADDR <= IADDR;
      end else if (complete || timeout) begin
        MREQ <= 1'b0;
      end
      if (complete || timeout) begin
        if (owner == OWN_I) begin
          IVALID <= 1'b1;
          IRDATA <= MREADY ? MRDATA : '0;
        end else begin
          DVALID <= 1'b1;
          if (!MRW) begin
            DRDATA <= MREADY ? MRDATA : '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_toy_mem_arbiter.sv
// Self-checking bench for toy_mem_arbiter: directed scenarios with literal
// expectations, then randomized requesters and memory against a transaction model.
module tb_toy_mem_arbiter;

  localparam int AW         = 30;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 3;
  localparam int TIMEOUT    = 15;

  logic          CLK;
  logic          RSTN;
  logic          IREQ;
  logic [AW-1:0] IADDR;
  logic [DW-1:0] IRDATA;
  logic          IVALID;
  logic          ISTALL;
  logic          DREQ;
  logic          DRW;
  logic [AW-1:0] DADDR;
  logic [DW-1:0] DWDATA;
  logic [DW-1:0] DRDATA;
  logic          DVALID;
  logic          DSTALL;
  logic          MREQ;
  logic          MRW;
  logic [AW-1:0] MADDR;
  logic [DW-1:0] MWDATA;
  logic [DW-1:0] MRDATA;
  logic          MREADY;
  logic          ERR;

  toy_mem_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IREQ(IREQ), .IADDR(IADDR), .IRDATA(IRDATA), .IVALID(IVALID), .ISTALL(ISTALL),
    .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA),
    .DVALID(DVALID), .DSTALL(DSTALL),
    .MREQ(MREQ), .MRW(MRW), .MADDR(MADDR), .MWDATA(MWDATA),
    .MRDATA(MRDATA), .MREADY(MREADY), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: at most one access in flight, described by its record.
  bit            m_inflight;
  bit            m_is_data;
  logic [AW-1:0] m_addr;
  bit            m_rw;
  logic [DW-1:0] m_wdata;
  bit            m_ivalid;
  bit            m_dvalid;
  bit            m_err;
  logic [DW-1:0] m_irdata;
  logic [DW-1:0] m_drdata;
  int            m_starve;
  int            m_age;
  int            fetch_done;
  int            data_done;
  int            mem_wait;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_inflight = 0; m_is_data = 0; m_addr = '0; m_rw = 0; m_wdata = '0;
    m_ivalid = 0; m_dvalid = 0; m_err = 0; m_irdata = '0; m_drdata = '0;
    m_starve = 0; m_age = 0; mem_wait = -1;
  endtask

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic model_edge();
    bit want_i, want_d, gi, gd, done, tmo, new_iv, new_dv;
    want_i = IREQ && !m_ivalid;
    want_d = DREQ && !m_dvalid;
    gi = 0; gd = 0; new_iv = 0; new_dv = 0;
    if (m_inflight) begin
      done = MREADY;
      tmo  = 0;
`ifdef ARB_TIMEOUT_EN
      if (!done) begin
        m_age++;
        if (m_age >= TIMEOUT) tmo = 1;
      end
`endif
      if (done || tmo) begin
        if (!m_is_data) begin
          m_irdata = done ? MRDATA : '0;
          new_iv = 1;
          fetch_done++;
        end else begin
          if (!m_rw) m_drdata = done ? MRDATA : '0;
          new_dv = 1;
          data_done++;
        end
        if (tmo) m_err = 1;
        m_inflight = 0;
      end
    end else begin
      if (want_d && (!want_i || m_starve < STARVE_MAX)) gd = 1;
      else if (want_i) gi = 1;
      if (gd) begin
        m_inflight = 1; m_is_data = 1; m_addr = DADDR; m_rw = DRW; m_wdata = DWDATA; m_age = 0;
      end
      if (gi) begin
        m_inflight = 1; m_is_data = 0; m_addr = IADDR; m_rw = 0; m_age = 0;
      end
    end
    if (!IREQ || gi) m_starve = 0;
    else if (gd && m_starve < STARVE_MAX) m_starve++;
    m_ivalid = new_iv;
    m_dvalid = new_dv;
  endtask

  // One clock: stall outputs mid-cycle, registered outputs just after the edge.
  task automatic cycle();
    @(negedge CLK);
    checkOutput("ISTALL", ISTALL, IREQ & ~m_ivalid);
    checkOutput("DSTALL", DSTALL, DREQ & ~m_dvalid);
    @(posedge CLK);
    #1;
    model_edge();
    checkOutput("MREQ", MREQ, m_inflight);
    checkOutput("IVALID", IVALID, m_ivalid);
    checkOutput("DVALID", DVALID, m_dvalid);
    checkOutput("IRDATA", IRDATA, m_irdata);
    checkOutput("DRDATA", DRDATA, m_drdata);
    checkOutput("ERR", ERR, m_err);
    if (m_inflight) begin
      checkOutput("MADDR", MADDR, m_addr);
      checkOutput("MRW", MRW, m_rw);
      if (m_rw) checkOutput("MWDATA", MWDATA, m_wdata);
    end
  endtask

  // Random requesters that obey the hold-until-VALID rule, plus a random-latency memory.
  task automatic applyStimulus();
    if (!IREQ) begin
      if ($urandom_range(0, 2) == 0) begin
        IREQ = 1; IADDR = AW'($urandom);
      end
    end else if (m_ivalid) begin
      if ($urandom_range(0, 1) == 0) IREQ = 0;
      else IADDR = AW'($urandom);
    end
    if (!DREQ) begin
      if ($urandom_range(0, 2) == 0) begin
        DREQ = 1; DRW = 1'($urandom); DADDR = AW'($urandom); DWDATA = $urandom;
      end
    end else if (m_dvalid) begin
      if ($urandom_range(0, 1) == 0) DREQ = 0;
      else begin
        DRW = 1'($urandom); DADDR = AW'($urandom); DWDATA = $urandom;
      end
    end
    MRDATA = $urandom;
    if (m_inflight) begin
      if (mem_wait < 0) mem_wait = $urandom_range(0, 4);
      MREADY = (mem_wait == 0);
      mem_wait--;
    end else begin
      mem_wait = -1;
      MREADY = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    bit quiet;
    RSTN = 0; IREQ = 0; IADDR = '0; DREQ = 0; DRW = 0; DADDR = '0; DWDATA = '0;
    MRDATA = '0; MREADY = 0;
    fetch_done = 0; data_done = 0;
    model_reset();
    #3;
    checkOutput("rst_MREQ", MREQ, 0);
    checkOutput("rst_MRW", MRW, 0);
    checkOutput("rst_MADDR", MADDR, 0);
    checkOutput("rst_MWDATA", MWDATA, 0);
    checkOutput("rst_IRDATA", IRDATA, 0);
    checkOutput("rst_DRDATA", DRDATA, 0);
    checkOutput("rst_IVALID", IVALID, 0);
    checkOutput("rst_DVALID", DVALID, 0);
    checkOutput("rst_ERR", ERR, 0);
    @(posedge CLK); #1;
    RSTN = 1;

    // Fetch only, memory answers in the first busy cycle.
    IREQ = 1; IADDR = 30'h10;
    cycle();
    checkOutput("t1_MADDR", MADDR, 30'h10);
    MREADY = 1; MRDATA = 32'h1234_5678;
    cycle();
    checkOutput("t1_IVALID", IVALID, 1);
    checkOutput("t1_IRDATA", IRDATA, 32'h1234_5678);
    checkOutput("t1_model_IRDATA", m_irdata, 32'h1234_5678);
    IREQ = 0; MREADY = 0;
    cycle();

    // Both request together: data first, fetch granted in the DVALID cycle.
    IREQ = 1; IADDR = 30'h44; DREQ = 1; DRW = 0; DADDR = 30'h20;
    cycle();
    checkOutput("t2_MADDR_d", MADDR, 30'h20);
    checkOutput("t2_MRW_d", MRW, 0);
    cycle();
    cycle();
    MREADY = 1; MRDATA = 32'hD00D_0020;
    cycle();
    checkOutput("t2_DVALID", DVALID, 1);
    checkOutput("t2_DRDATA", DRDATA, 32'hD00D_0020);
    DREQ = 0; MREADY = 0;
    cycle();
    checkOutput("t2_MREQ_i", MREQ, 1);
    checkOutput("t2_MADDR_i", MADDR, 30'h44);
    checkOutput("t2_model_MADDR", m_addr, 30'h44);
    MREADY = 1; MRDATA = 32'hABCD_0044;
    cycle();
    checkOutput("t2_IRDATA", IRDATA, 32'hABCD_0044);
    IREQ = 0; MREADY = 0;
    cycle();

    // Store leaves DRDATA untouched even with junk on MRDATA.
    DREQ = 1; DRW = 1; DADDR = 30'h3; DWDATA = 32'hCAFE_0001;
    cycle();
    checkOutput("t4_MRW", MRW, 1);
    checkOutput("t4_MWDATA", MWDATA, 32'hCAFE_0001);
    checkOutput("t4_MADDR", MADDR, 30'h3);
    MREADY = 1; MRDATA = 32'hFFFF_EEEE;
    cycle();
    checkOutput("t4_DVALID", DVALID, 1);
    checkOutput("t4_DRDATA", DRDATA, 32'hD00D_0020);
    DREQ = 0; MREADY = 0;
    cycle();

    // MREADY while idle is ignored.
    MREADY = 1; MRDATA = 32'h5555_AAAA;
    cycle();
    checkOutput("idle_MREQ", MREQ, 0);
    checkOutput("idle_DVALID", DVALID, 0);
    MREADY = 0;
    cycle();

    // Asynchronous reset while a data read is in flight.
    DREQ = 1; DRW = 0; DADDR = 30'h7;
    cycle();
    checkOutput("t5_MREQ_busy", MREQ, 1);
    #2;
    RSTN = 0;
    #1;
    checkOutput("t5_MREQ_async", MREQ, 0);
    DREQ = 0;
    model_reset();
    @(posedge CLK); #1;
    RSTN = 1;
    cycle();
    checkOutput("t5_no_DVALID", DVALID, 0);
    cycle();
    IREQ = 1; IADDR = 30'h55;
    cycle();
    checkOutput("t5_MADDR", MADDR, 30'h55);
    checkOutput("t5_MRW", MRW, 0);
    MREADY = 1; MRDATA = 32'h0BAD_F00D;
    cycle();
    checkOutput("t5_IVALID", IVALID, 1);
    IREQ = 0; MREADY = 0;
    cycle();

    // Randomized traffic.
    repeat (3000) begin
      applyStimulus();
      cycle();
    end

    // Let outstanding requests finish, keeping each REQ up until its VALID.
    quiet = 0;
    for (int i = 0; i < 60 && !quiet; i++) begin
      if (m_ivalid) IREQ = 0;
      if (m_dvalid) DREQ = 0;
      MREADY = m_inflight;
      cycle();
      quiet = !IREQ && !DREQ && !m_inflight && !m_ivalid && !m_dvalid;
    end
    checkOutput("drain_idle", quiet, 1);
    MREADY = 0;
    checkOutput("fetch_progress", fetch_done > 50, 1);
    checkOutput("data_progress", data_done > 50, 1);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: abort after TIMEOUT busy cycles.
    IREQ = 1; IADDR = 30'h9;
    cycle();
    repeat (14) cycle();
    checkOutput("tmo_MREQ_hold", MREQ, 1);
    cycle();
    checkOutput("tmo_MREQ", MREQ, 0);
    checkOutput("tmo_IVALID", IVALID, 1);
    checkOutput("tmo_IRDATA", IRDATA, 0);
    checkOutput("tmo_ERR", ERR, 1);
    IREQ = 0;
    cycle();
    cycle();
    checkOutput("tmo_ERR_sticky", ERR, 1);
    #2;
    RSTN = 0;
    #1;
    checkOutput("tmo_ERR_reset", ERR, 0);
    model_reset();
    @(posedge CLK); #1;
    RSTN = 1;
    cycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/toy_mem_arbiter.md
# toy_mem_arbiter

Shares a single external single-port memory between the RISC_TOY fetch port (IF stage) and data port (MEM stage). Each port issues a level request and receives a one-cycle valid pulse. Data requests take priority, and a starvation counter guarantees fetch progress. The block drives the pipeline stall inputs and hides memory wait states from the core.

## Interface
- AW, 30, word-address width
- DW, 32, data width
- STARVE_MAX, 3, consecutive data grants with fetch pending before fetch is forced (>=1)
- TIMEOUT, 15, busy cycles without MREADY before abort (only with ARB_TIMEOUT_EN)

Ports:
- CLK  in  1  clock; everything is rising-edge
- RSTN  in  1  reset; asynchronous, active-low
- IREQ  in  1  fetch request (level)
- IADDR  in  AW  fetch word address
- IRDATA  out  DW  fetched word; registered
- IVALID  out  1  fetch-complete pulse
- ISTALL  out  1  IREQ & ~IVALID; combinational
- DREQ  in  1  data request (level)
- DRW  in  1  1 = write, 0 = read
- DADDR  in  AW  data word address
- DWDATA  in  DW  store data
- DRDATA  out  DW  load data; registered
- DVALID  out  1  data-complete pulse
- DSTALL  out  1  DREQ & ~DVALID; combinational
- MREQ  out  1  memory request; registered
- MRW  out  1  memory direction, 1 = write
- MADDR  out  AW  memory address
- MWDATA  out  DW  memory write data
- MRDATA  in  DW  memory read data, valid in the MREADY cycle
- MREADY  in  1  memory completion, single-cycle
- ERR  out  1  sticky timeout flag

## Operation
- States:
  - IDLE: no memory access in flight.
  - IBUSY: fetch access in flight.
  - DBUSY: data access in flight.
- Requester rules: hold REQ, address and write data stable until its VALID pulse. Dropping REQ early while busy is illegal.
- Arbitration in IDLE. A requester whose VALID is high this cycle is ignored. Then:
  - only DREQ -> DBUSY
  - only IREQ -> IBUSY
  - both -> DBUSY if starve_cnt < STARVE_MAX, else IBUSY
- Grant edge: MADDR, MRW, MWDATA latched from the winner; MREQ=1. A fetch grant always drives MRW=0.
- starve_cnt:
  - +1 on a data grant while IREQ=1
  - cleared on a fetch grant, or on any cycle with IREQ=0
  - saturates at STARVE_MAX
- Busy state with MREADY=1:
  - read: MRDATA captured into IRDATA or DRDATA
  - MREQ->0, state->IDLE, owner VALID=1 for exactly the next cycle
  - write: DRDATA unchanged
- IRDATA/DRDATA hold their value until the next completion on that port.

## Timing
- Reset values: MREQ 0, MRW 0, MADDR 0, MWDATA 0, IRDATA 0, DRDATA 0, IVALID 0, DVALID 0, ERR 0, starve_cnt 0, state IDLE.
- Latency: REQ seen at cycle 0 -> MREQ high in cycle 1 -> MREADY in cycle k>=1 -> VALID in cycle k+1. Minimum 2 cycles.
- Back-to-back:
  - Another port can be granted in the VALID cycle (MREQ high again next cycle).
  - The same port needs one bubble.
- MREADY while IDLE is ignored.
- Asynchronous reset mid-access: MREQ drops immediately, the transaction is abandoned, no VALID is issued.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A busy counter clears on grant and increments each busy cycle.
  - If it reaches TIMEOUT with MREADY=0: MREQ->0, owner VALID pulses with read data 0, ERR=1 until reset.
  - MREADY in the same cycle as the timeout wins; it is a normal completion and ERR stays 0.
- ARB_TIMEOUT_EN undefined: no counter, ERR tied 0, the block waits for MREADY indefinitely.

## Structure
- Package toy_arb_pkg holds:
  - state enum: IDLE, IBUSY, DBUSY
  - owner encoding
  - defaults for STARVE_MAX and TIMEOUT
- Sub-module toy_arb_pick:
  - holds starve_cnt and the priority decision
  - inputs: IREQ, DREQ, IVALID, DVALID, state
  - outputs: grant_i, grant_d
- Top module holds:
  - state register
  - memory output registers
  - read-data capture registers
  - optional timeout counter

## Test plan
- Fetch only, IADDR=0x10, memory returns MRDATA=0x1234_5678 with MREADY in cycle 1 -> MADDR=0x10, IVALID in cycle 2, IRDATA=0x1234_5678, ISTALL high in cycles 0-1.
- IREQ and DREQ rise together, DRW=0, DADDR=0x20, MREADY delayed 3 cycles -> data served first, DVALID in cycle 4, fetch MREQ in cycle 5 with MADDR=IADDR.
- DREQ continuously re-asserted, IREQ held, STARVE_MAX=3 -> exactly 3 data grants, then a fetch grant, then starve_cnt=0.
- Store with DADDR=0x3, DWDATA=0xCAFE_0001 -> MRW=1, MWDATA=0xCAFE_0001, DVALID pulses, DRDATA keeps its previous value.
- RSTN low while in DBUSY -> MREQ=0 immediately, no DVALID after release, next grant behaves as from reset.
- ARB_TIMEOUT_EN, TIMEOUT=15, MREADY never asserted -> MREQ drops after 15 busy cycles, owner VALID with data 0, ERR=1 until reset.
